// File: rtl/mul32_seq_ctrl_if.sv
// Bus between the sequential multiplier controller, its requester and the
// external shared 32-bit adder.
interface mul32_seq_ctrl_if;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_ci;
   logic [31:0] add_sum;
   logic        add_co;
   logic        busy;
   logic        done;
   logic [31:0] product_lo;
   logic [31:0] product_hi;

   modport slave (
      input  start, op_a, op_b, add_sum, add_co,
      output add_a, add_b, add_ci, busy, done, product_lo, product_hi
   );

   modport master (
      output start, op_a, op_b, add_sum, add_co,
      input  add_a, add_b, add_ci, busy, done, product_lo, product_hi
   );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// 32x32 unsigned shift-add multiplier controller; one partial-product step per
// cycle through an external combinational adder, 33 cycles start-to-done.
module mul32_seq_ctrl #(
   parameter int unsigned UUID = 0,
   parameter              NAME = ""
) (
   input  logic            clk,
   input  logic            rst,
   mul32_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] p_hi_q,  p_hi_d;
   logic [31:0] p_lo_q,  p_lo_d;
   logic [5:0]  cnt_q,   cnt_d;
   logic [31:0] add_a_c;
   logic [31:0] add_b_c;

   // Instance tags carry no function; folded into a sink so they stay referenced.
   logic unused_cfg;
   assign unused_cfg = ^{UUID, $bits(NAME)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      p_hi_d  = p_hi_q;
      p_lo_d  = p_lo_q;
      cnt_d   = cnt_q;
      add_a_c = '0;
      add_b_c = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.op_a;
               p_lo_d  = bus.op_b;
               p_hi_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            add_a_c = p_hi_q;
            add_b_c = p_lo_q[0] ? mcand_q : '0;
            // 64-bit right shift of {carry, sum, P_lo}; the sum LSB enters P_lo.
            p_hi_d  = {bus.add_co, bus.add_sum[31:1]};
            p_lo_d  = {bus.add_sum[0], p_lo_q[31:1]};
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.add_a      = add_a_c;
   assign bus.add_b      = add_b_c;
   assign bus.add_ci     = 1'b0;
   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == DONE);
   assign bus.product_lo = p_lo_q;
   assign bus.product_hi = p_hi_q;

endmodule

// File: doc/mul32_seq_ctrl.md
MUL32_SEQ_CTRL -- requirements
Module: mul32_seq_ctrl

Interface
REQ-001 Parameter UUID, default 0, instance identifier; SHALL NOT affect function.
REQ-002 Parameter NAME, default "", instance label; SHALL NOT affect function.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request a multiply; sampled only in IDLE.
REQ-006 op_a  in  32  multiplicand, unsigned; captured on the accepting edge.
REQ-007 op_b  in  32  multiplier, unsigned; captured on the accepting edge.
REQ-008 add_a  out  32  operand A to the external shared 32-bit adder.
REQ-009 add_b  out  32  operand B to the external adder.
REQ-010 add_ci  out  1  adder carry-in; SHALL be constant 0.
REQ-011 add_sum  in  32  adder sum, combinational from add_a/add_b/add_ci.
REQ-012 add_co  in  1  adder carry-out.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  one-cycle pulse; product valid.
REQ-015 product_lo  out  32  product bits [31:0].
REQ-016 product_hi  out  32  product bits [63:32].

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE, one-hot or encoded.
REQ-018 IDLE with start=1 SHALL capture mcand<=op_a, P_lo<=op_b, P_hi<=0, cnt<=0, and go to RUN.
REQ-019 IDLE with start=0 SHALL stay in IDLE and hold all registers.
REQ-020 In RUN: add_a=P_hi; add_b=mcand if P_lo[0]=1, else 0.
REQ-021 Each RUN edge SHALL do P_hi<={add_co, add_sum[31:1]}, P_lo<={add_sum[0], P_lo[31:1]}, and cnt<=cnt+1.
REQ-022 cnt SHALL be 6 bits; on the RUN edge where cnt=31 the FSM SHALL go to DONE; RUN therefore lasts exactly 32 cycles regardless of operand values.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-024 Latency: the start-accepting edge is edge 0; done SHALL be high during the cycle after edge 32 (33 cycles start-to-done).
REQ-025 product_hi/product_lo SHALL be driven from P_hi/P_lo and SHALL equal op_a*op_b (full 64-bit unsigned) while done=1; the value SHALL hold through IDLE until the next accepted start.
REQ-026 start during RUN or DONE SHALL be ignored, neither queued nor restarting; op_a/op_b changes after capture SHALL have no effect.
REQ-027 Back-to-back: start=1 in the IDLE cycle immediately after DONE SHALL be accepted; minimum issue interval 34 cycles.
REQ-028 add_a and add_b SHALL be 0 in IDLE and DONE.
REQ-029 Adder outputs SHALL be consumed only in RUN; the adder SHALL be treated as purely combinational, with no handshake.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, with P_hi=P_lo=mcand=0 and cnt=0; this takes priority over start.
REQ-031 After reset: busy=0, done=0, product_lo=product_hi=0, add_a=add_b=0, add_ci=0.
REQ-032 rst asserted mid-RUN SHALL abort the operation without a done pulse; the first start after release SHALL run a full 32-cycle operation.

Verification (bench models the adder as add_sum/add_co = add_a+add_b+add_ci)
REQ-033 op_a=3, op_b=5, start 1 cycle -> busy high 32 cycles; done at cycle 33; product_hi=0, product_lo=0x0000000F.
REQ-034 op_a=op_b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001; exercises carry-out on each step.
REQ-035 op_a=0x12345678, op_b=0 -> product 0; latency still 33; add_b=0 every RUN cycle.
REQ-036 start pulsed at RUN cycle 10 with different operands -> ignored; first result unchanged; single done pulse.
REQ-037 rst at RUN cycle 20 -> next cycle IDLE, all outputs 0, no done; then 7*6 -> product_lo=0x2A at cycle 33.
REQ-038 Back-to-back: start held high continuously -> done pulses every 34 cycles; product holds between them; random 1000-op compare against a 64-bit reference model.
